// File: rtl/babbage_pkg.sv
// Shared definitions for the Babbage difference-engine front end.
package babbage_pkg;

    localparam int N_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DWELL = 2'd3
    } req_state_e;

endpackage

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector: rise_o is high while sig_i=1 and the previous sample was 0.
module rise_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/babbage_req_ctrl.sv
// Request controller: turns button presses into single or sweeping engine evaluations,
// with range checking, engine timeout and sweep abort.
module babbage_req_ctrl
    import babbage_pkg::*;
#(
    parameter int N_MAX   = 63,
    parameter int DWELL   = 50_000_000,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           btn,
    input  logic           mode_sweep,
    input  logic [N_W-1:0] n_sw,
    input  logic           eng_done,
    output logic           eng_start,
    output logic [N_W-1:0] eng_n,
    output logic           busy,
    output logic           done_tick,
    output logic           err_range,
    output logic           err_timeout
);

    localparam int DW_W = $clog2(DWELL + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    req_state_e     state_q, state_d;
    logic [N_W-1:0] eng_n_q, eng_n_d;
    logic [N_W-1:0] bound_q, bound_d;
    logic           sweep_q, sweep_d;
    logic           abort_q, abort_d;
    logic           done_q, done_d;
    logic           err_range_q, err_range_d;
    logic           err_to_q, err_to_d;
    logic [DW_W-1:0] dw_cnt_q, dw_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic           rise;

    rise_edge_det u_btn_edge (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sig_i  (btn),
        .rise_o (rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            eng_n_q     <= '0;
            bound_q     <= '0;
            sweep_q     <= 1'b0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            err_range_q <= 1'b0;
            err_to_q    <= 1'b0;
            dw_cnt_q    <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            eng_n_q     <= eng_n_d;
            bound_q     <= bound_d;
            sweep_q     <= sweep_d;
            abort_q     <= abort_d;
            done_q      <= done_d;
            err_range_q <= err_range_d;
            err_to_q    <= err_to_d;
            dw_cnt_q    <= dw_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Counters default to zero so they restart on every state entry.
    always_comb begin
        state_d     = state_q;
        eng_n_d     = eng_n_q;
        bound_d     = bound_q;
        sweep_d     = sweep_q;
        abort_d     = abort_q;
        done_d      = 1'b0;
        err_range_d = err_range_q;
        err_to_d    = err_to_q;
        dw_cnt_d    = '0;
        to_cnt_d    = '0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (rise) begin
                    if (int'(n_sw) > N_MAX) begin
                        err_range_d = 1'b1;
                    end else begin
                        err_range_d = 1'b0;
                        err_to_d    = 1'b0;
                        sweep_d     = mode_sweep;
                        bound_d     = n_sw;
                        eng_n_d     = mode_sweep ? '0 : n_sw;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (sweep_q && rise) begin
                    abort_d = 1'b1;
                end
                // A reply in the final timeout cycle still counts as success.
                if (eng_done) begin
                    if (!sweep_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (abort_d) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DWELL;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DWELL: begin
                dw_cnt_d = dw_cnt_q + 1'b1;
                if (rise) begin
                    abort_d = 1'b1;
                end
                if (dw_cnt_q == DW_LAST) begin
                    if (abort_d) begin
                        state_d = ST_IDLE;
                    end else if (eng_n_q < bound_q) begin
                        eng_n_d = eng_n_q + 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eng_start   = (state_q == ST_ISSUE);
    assign eng_n       = eng_n_q;
    assign busy        = (state_q != ST_IDLE);
    assign done_tick   = done_q;
    assign err_range   = err_range_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_babbage_req_ctrl.sv
// Directed bench for babbage_req_ctrl with a delay-programmable engine model.
module tb_babbage_req_ctrl;

    localparam int DW = 4;
    localparam int TO = 16;

    logic       clk, rst_n, btn, mode_sweep, eng_done;
    logic [5:0] n_sw;
    logic       eng_start, busy, done_tick, err_range, err_timeout;
    logic [5:0] eng_n;
    logic       r_eng_start, r_busy, r_done_tick, r_err_range, r_err_timeout;
    logic [5:0] r_eng_n;

    babbage_req_ctrl #(.N_MAX(63), .DWELL(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .mode_sweep(mode_sweep), .n_sw(n_sw),
        .eng_done(eng_done), .eng_start(eng_start), .eng_n(eng_n), .busy(busy),
        .done_tick(done_tick), .err_range(err_range), .err_timeout(err_timeout)
    );

    // Same stimulus, lower N_MAX, for the range check.
    babbage_req_ctrl #(.N_MAX(40), .DWELL(DW), .TIMEOUT(TO)) dut_r (
        .clk(clk), .rst_n(rst_n), .btn(btn), .mode_sweep(mode_sweep), .n_sw(n_sw),
        .eng_done(eng_done), .eng_start(r_eng_start), .eng_n(r_eng_n), .busy(r_busy),
        .done_tick(r_done_tick), .err_range(r_err_range), .err_timeout(r_err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: event counts and logs, only ever written here.
    int         n_starts = 0, n_done = 0, done_cyc = 0, eto_cyc = 0;
    int         r_starts = 0, r_busy_cnt = 0, r_done = 0;
    int         st_cyc [64];
    logic [5:0] st_n   [64];
    logic       eto_prev = 1'b0;

    always @(negedge clk) begin
        if (eng_start === 1'b1) begin
            if (n_starts < 64) begin
                st_n[n_starts]   <= eng_n;
                st_cyc[n_starts] <= cyc;
            end
            n_starts <= n_starts + 1;
        end
        if (done_tick === 1'b1) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (err_timeout === 1'b1 && !eto_prev) eto_cyc <= cyc;
        eto_prev <= (err_timeout === 1'b1);
        if (r_eng_start === 1'b1) r_starts <= r_starts + 1;
        if (r_busy === 1'b1) r_busy_cnt <= r_busy_cnt + 1;
        if (r_done_tick === 1'b1) r_done <= r_done + 1;
    end

    // Engine model: eng_done pulses in the eng_delay-th cycle after the eng_start cycle; 0 = never.
    int eng_delay = 0;
    int eng_cnt   = -1;
    initial begin
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_cnt  = -1;
                end
            end
            if (eng_start === 1'b1 && eng_delay > 0) eng_cnt = eng_delay;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic press();
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " returns idle"}, int'(busy === 1'b0), 1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        bit         sweep;
        logic [5:0] n;
        int         delay;
        int         exp_starts;
        int         exp_done;
        int         exp_eto;
        int         exp_lat;   // first eng_start to done_tick, or to err_timeout rise
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_st, b_dn, b_rs, b_rb, last, found;

        vecs[0] = '{1'b0, 6'd5,  10, 1, 1, 0, 11};
        vecs[1] = '{1'b0, 6'd0,  1,  1, 1, 0, 2};
        vecs[2] = '{1'b0, 6'd63, 3,  1, 1, 0, 4};
        vecs[3] = '{1'b0, 6'd9,  16, 1, 1, 0, 17};
        vecs[4] = '{1'b0, 6'd9,  0,  1, 0, 1, 17};
        vecs[5] = '{1'b0, 6'd7,  17, 1, 0, 1, 17};
        vecs[6] = '{1'b1, 6'd3,  2,  4, 1, 0, 28};
        vecs[7] = '{1'b1, 6'd0,  1,  1, 1, 0, 6};

        rst_n = 1'b0; btn = 1'b0; mode_sweep = 1'b0; n_sw = 6'd0;
        repeat (3) @(negedge clk);
        check("reset eng_start", int'(eng_start), 0);
        check("reset eng_n", int'(eng_n), 0);
        check("reset busy", int'(busy), 0);
        check("reset done_tick", int'(done_tick), 0);
        check("reset err_range", int'(err_range), 0);
        check("reset err_timeout", int'(err_timeout), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            b_st = n_starts;
            b_dn = n_done;
            mode_sweep = vecs[i].sweep;
            n_sw       = vecs[i].n;
            eng_delay  = vecs[i].delay;
            press();
            wait_idle(300, $sformatf("v%0d", i));
            check($sformatf("v%0d start count", i), n_starts - b_st, vecs[i].exp_starts);
            check($sformatf("v%0d done count", i), n_done - b_dn, vecs[i].exp_done);
            check($sformatf("v%0d err_timeout", i), int'(err_timeout), vecs[i].exp_eto);
            check($sformatf("v%0d err_range", i), int'(err_range), 0);
            last = b_st + vecs[i].exp_starts - 1;
            check($sformatf("v%0d final eng_n", i), int'(st_n[last]), int'(vecs[i].n));
            if (vecs[i].sweep) begin
                for (int j = 1; j < vecs[i].exp_starts; j++) begin
                    check($sformatf("v%0d step%0d eng_n", i, j), int'(st_n[b_st + j]), j);
                    check($sformatf("v%0d step%0d spacing", i, j),
                          st_cyc[b_st + j] - st_cyc[b_st + j - 1], 1 + vecs[i].delay + DW);
                end
            end
            if (vecs[i].exp_done != 0)
                check($sformatf("v%0d done latency", i), done_cyc - st_cyc[b_st], vecs[i].exp_lat);
            else
                check($sformatf("v%0d timeout latency", i), eto_cyc - st_cyc[b_st], vecs[i].exp_lat);
        end

        // Range rejection on the N_MAX=40 instance; its eng_n is 0 from the last sweep (n=0).
        b_rs = r_starts; b_rb = r_busy_cnt; b_st = n_starts;
        mode_sweep = 1'b0; n_sw = 6'd41; eng_delay = 2;
        press();
        wait_idle(100, "range41");
        check("range err_range set", int'(r_err_range), 1);
        check("range no eng_start", r_starts - b_rs, 0);
        check("range busy stays 0", r_busy_cnt - b_rb, 0);
        check("range eng_n unchanged", int'(r_eng_n), 0);
        check("range 63-instance accepts 41", int'(st_n[b_st]), 41);
        b_rs = r_starts;
        n_sw = 6'd2;
        press();
        wait_idle(100, "range2");
        check("range err_range cleared", int'(r_err_range), 0);
        check("range accepted start", r_starts - b_rs, 1);
        check("range accepted eng_n", int'(r_eng_n), 2);
        check("range no timeout", int'(r_err_timeout), 0);

        // Abort during the WAIT of step n=1 of a sweep to 5.
        b_st = n_starts; b_dn = n_done;
        mode_sweep = 1'b1; n_sw = 6'd5; eng_delay = 3;
        press();
        found = 0;
        for (int t = 0; t < 100 && found == 0; t++) begin
            @(negedge clk);
            if (eng_start === 1'b1 && eng_n == 6'd1) found = 1;
        end
        check("abort reached step 1", found, 1);
        @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        wait_idle(200, "abort");
        check("abort start count", n_starts - b_st, 2);
        check("abort no done_tick", n_done - b_dn, 0);
        check("abort last eng_n", int'(st_n[b_st + 1]), 1);

        b_st = n_starts; b_dn = n_done;
        mode_sweep = 1'b0; n_sw = 6'd4; eng_delay = 2;
        press();
        wait_idle(100, "post-abort");
        check("post-abort start", n_starts - b_st, 1);
        check("post-abort done", n_done - b_dn, 1);

        // Reset in the third WAIT cycle; the engine still answers later.
        b_st = n_starts; b_dn = n_done;
        mode_sweep = 1'b0; n_sw = 6'd12; eng_delay = 8;
        press();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset eng_start", int'(eng_start), 0);
        check("midreset eng_n", int'(eng_n), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done_tick", int'(done_tick), 0);
        check("midreset err_timeout", int'(err_timeout), 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midreset no done_tick later", n_done - b_dn, 0);
        check("midreset no extra start", n_starts - b_st, 1);
        check("midreset stays idle", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
